// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window MAC and the layer
// accumulators. Fixed-point format is Q4.11 in a signed 16-bit word.
package conv_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 11;
  localparam int MAX_K     = 5;
  localparam int WIN_ELEMS = MAX_K * MAX_K;
  localparam int ACC_W     = 40;
  localparam int IDX_W     = $clog2(WIN_ELEMS);

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef data_t win_arr_t [0:WIN_ELEMS-1];

  localparam data_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam data_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    SCALE = 2'd2
  } state_t;

endpackage

// File: rtl/fx_scale_sat.sv
// Scales a wide accumulator back to the data format and saturates it.
// Build option CONV_ROUND_EN: add half an LSB before the shift (round half
// up); without it the arithmetic shift floors toward negative infinity.
module fx_scale_sat
  import conv_pkg::*;
(
  input  acc_t  acc,
  output data_t result
);

  localparam acc_t HALF_LSB = acc_t'(1) <<< (FRAC_BITS - 1);
  localparam acc_t ACC_MAX  = acc_t'(SAT_MAX);
  localparam acc_t ACC_MIN  = acc_t'(SAT_MIN);

  acc_t biased;
  acc_t shifted;

  // Optional rounding bias, arithmetic shift, then clamp to the data range.
  always_comb begin
`ifdef CONV_ROUND_EN
    biased = acc + HALF_LSB;
`else
    biased = acc;
`endif
    shifted = biased >>> FRAC_BITS;
    if (shifted > ACC_MAX)
      result = SAT_MAX;
    else if (shifted < ACC_MIN)
      result = SAT_MIN;
    else
      result = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/conv_window_mac.sv
// Sequential dot product of one convolution window against a 3x3 or 5x5
// kernel, one product per cycle, scaled and saturated on output.
// Build option CONV_ROUND_EN selects rounding in fx_scale_sat.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// MAC   | accumulating window_r[index] * filter_r[index]
// SCALE | registering the scaled result and strobing out_valid
module conv_window_mac
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  win_arr_t    window,
  input  win_arr_t    filter,
  input  logic [15:0] size,
  output data_t       value,
  output logic        out_valid,
  output logic        busy
);

  state_t             state;
  acc_t               acc;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_idx;
  win_arr_t           window_r;
  win_arr_t           filter_r;
  logic signed [2*DATA_W-1:0] prod;
  data_t              scaled;

  assign prod = window_r[idx] * filter_r[idx];

  fx_scale_sat u_scale (
    .acc    (acc),
    .result (scaled)
  );

  // Operand capture on accept; no reset needed since nothing reads them in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      window_r <= window;
      filter_r <= filter;
    end
  end

  // Job sequencing, accumulation and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      value     <= '0;
      acc       <= '0;
      idx       <= '0;
      last_idx  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= '0;
            idx      <= '0;
            last_idx <= (size == 16'd3) ? IDX_W'(8) : IDX_W'(WIN_ELEMS - 1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc + acc_t'(prod);
          idx <= idx + 1'b1;
          if (idx == last_idx)
            state <= SCALE;
        end
        SCALE: begin
          value     <= scaled;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Randomized and directed bench for conv_window_mac with an arithmetic
// reference model of the windowed dot product.
module tb_conv_window_mac;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  win_arr_t    window;
  win_arr_t    filter;
  logic [15:0] size;
  data_t       value;
  logic        out_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_window_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .window    (window),
    .filter    (filter),
    .size      (size),
    .value     (value),
    .out_valid (out_valid),
    .busy      (busy)
  );

  // Reference: exact integer dot product, divide by 2^FRAC_BITS with floor
  // (optionally after +0.5 LSB), clamp to the signed 16-bit range.
  function automatic data_t model(input win_arr_t w, input win_arr_t f, input logic [15:0] sz);
    longint sum = 0;
    longint q;
    int n = (sz == 16'd3) ? 9 : 25;
    for (int i = 0; i < n; i++)
      sum += longint'(w[i]) * longint'(f[i]);
`ifdef CONV_ROUND_EN
    sum += 1024;
`endif
    q = sum / 2048;
    if ((sum % 2048) != 0 && sum < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return data_t'(q);
  endfunction

  function automatic data_t rand_elem();
    data_t d = data_t'($urandom);
    return d >>> $urandom_range(0, 10);
  endfunction

  task automatic fill(output win_arr_t w, output win_arr_t f);
    for (int i = 0; i < WIN_ELEMS; i++) begin
      w[i] = rand_elem();
      f[i] = rand_elem();
    end
  endtask

  // Waits for in_ready, presents a job, returns just after the accept edge.
  task automatic start_job(input win_arr_t w, input win_arr_t f, input logic [15:0] sz, input bit scribble);
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    window = w; filter = f; size = sz; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (scribble) begin
      for (int i = 0; i < WIN_ELEMS; i++) begin
        window[i] = data_t'($urandom);
        filter[i] = data_t'($urandom);
      end
      size = (sz == 16'd3) ? 16'd5 : 16'd3;
    end
  endtask

  task automatic wait_result(output data_t got, output int lat, output bit ok);
    ok = 1'b0; lat = 0; got = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin ok = 1'b1; got = value; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; size = 16'd5;
    for (int i = 0; i < WIN_ELEMS; i++) begin window[i] = '0; filter[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h exp=0000", value); end
  endtask

  task automatic test_directed();
    win_arr_t w, f;
    logic [15:0] szs [6] = '{16'd5, 16'd3, 16'd5, 16'd5, 16'd5, 16'd5};
    data_t ws [6] = '{16'h0400, 16'h0400, 16'h0800, 16'hB000, 16'h0001, 16'hFFFF};
    data_t fs [6] = '{16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0C00, 16'h0C00};
    bit    one[6] = '{0, 0, 0, 0, 1, 1};
`ifdef CONV_ROUND_EN
    data_t ex [6] = '{16'h6400, 16'h2400, 16'h7FFF, 16'h8000, 16'h0002, 16'hFFFF};
`else
    data_t ex [6] = '{16'h6400, 16'h2400, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFE};
`endif
    data_t got; int lat; bit ok;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < WIN_ELEMS; i++) begin
        w[i] = (one[t] && i != 0) ? data_t'(0) : ws[t];
        f[i] = (one[t] && i != 0) ? data_t'(0) : fs[t];
      end
      if (szs[t] == 16'd3)
        for (int i = 9; i < WIN_ELEMS; i++) begin w[i] = data_t'($urandom); f[i] = data_t'($urandom); end
      start_job(w, f, szs[t], 1'b1);
      wait_result(got, lat, ok);
      total++; if (!ok) begin bad++; $display("FAIL directed%0d_timeout no out_valid", t); end
      total++; if (got !== ex[t]) begin bad++; $display("FAIL directed%0d_value got=%h exp=%h", t, got, ex[t]); end
      total++; if (lat != ((szs[t] == 16'd3) ? 10 : 26)) begin bad++; $display("FAIL directed%0d_latency got=%0d exp=%0d", t, lat, (szs[t] == 16'd3) ? 10 : 26); end
    end
  endtask

  task automatic test_random();
    win_arr_t w, f;
    logic [15:0] sz;
    data_t got, exp_v; int lat; bit ok;
    for (int t = 0; t < 24; t++) begin
      fill(w, f);
      case ($urandom_range(0, 2))
        0: sz = 16'd3;
        1: sz = 16'd5;
        default: sz = 16'($urandom) | 16'h0100;
      endcase
      exp_v = model(w, f, sz);
      start_job(w, f, sz, 1'b1);
      wait_result(got, lat, ok);
      total++;
      if (!ok || got !== exp_v || lat != ((sz == 16'd3) ? 10 : 26)) begin
        bad++;
        $display("FAIL random%0d size=%0d got=%h lat=%0d exp=%h lat=%0d", t, sz, got, lat, exp_v, (sz == 16'd3) ? 10 : 26);
      end
    end
  endtask

  task automatic test_abort();
    win_arr_t w, f;
    int seen = 0;
    fill(w, f);
    start_job(w, f, 16'd5, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_out_valid got=%0d strobes exp=0", seen); end
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got ready=%b busy=%b exp ready=1 busy=0", in_ready, busy); end
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL abort_value got=%h exp=0000", value); end
  endtask

  task automatic test_busy_ignore();
    win_arr_t w, f, w2, f2;
    data_t exp_v, got = '0;
    int lat = 0, extra = 0;
    bit ok = 1'b0;
    fill(w, f); fill(w2, f2);
    exp_v = model(w, f, 16'd5);
    start_job(w, f, 16'd5, 1'b0);
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 8) begin
        window = w2; filter = f2; size = 16'd3; in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (busy !== 1'b1 && !out_valid) begin bad++; total++; $display("FAIL busy_flag got=%b exp=1 at cycle %0d", busy, lat); end
      if (out_valid) begin ok = 1'b1; got = value; end
    end
    in_valid = 1'b0;
    total++; if (!ok || got !== exp_v) begin bad++; $display("FAIL busy_ignore_value got=%h exp=%h", got, exp_v); end
    total++; if (lat != 26) begin bad++; $display("FAIL busy_ignore_latency got=%0d exp=26", lat); end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL busy_ignore_queued got=%0d strobes exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    win_arr_t w1, f1, w2, f2;
    data_t got; int lat; bit ok;
    data_t e1, e2;
    bit rdy;
    fill(w1, f1); fill(w2, f2);
    e1 = model(w1, f1, 16'd3);
    e2 = model(w2, f2, 16'd5);
    start_job(w1, f1, 16'd3, 1'b0);
    wait_result(got, lat, ok);
    rdy = in_ready;
    total++; if (!ok || got !== e1 || lat != 10) begin bad++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=10", got, lat, e1); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready_with_strobe got=%b exp=1", rdy); end
    start_job(w2, f2, 16'd5, 1'b1);
    wait_result(got, lat, ok);
    total++; if (!ok || got !== e2 || lat != 26) begin bad++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=26", got, lat, e2); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
